// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide synchronous-read RAM port between instruction fetch (IF)
// and load/store (MEM). Define MEM_CTRL_RR_EN for round-robin arbitration instead of MEM-first.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              ram_en_o,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_data_i
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_IF_RD  = 2'd1;
    localparam logic [1:0] ST_MEM_RD = 2'd2;
    localparam logic [1:0] ST_MEM_WR = 2'd3;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   len_bytes = 3'd1;
            2'b01:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    get_lane = w[7:0];
            2'd1:    get_lane = w[15:8];
            2'd2:    get_lane = w[23:16];
            default: get_lane = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        put_lane = w;
        case (lane)
            2'd0:    put_lane[7:0]   = b;
            2'd1:    put_lane[15:8]  = b;
            2'd2:    put_lane[23:16] = b;
            default: put_lane[31:24] = b;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              grant_mem_s, grant_if_s;
    logic [2:0]        nxt_s;

`ifdef MEM_CTRL_RR_EN
    logic last_mem_q, last_mem_d;

    // Round-robin grant: when both pend, serve the requester not granted last time.
    always_comb begin
        if (mem_req_i && if_req_i) begin
            grant_mem_s = !last_mem_q;
        end else begin
            grant_mem_s = mem_req_i;
        end
        grant_if_s = if_req_i && !grant_mem_s;
        if ((state_q == ST_IDLE) && (grant_mem_s || grant_if_s)) begin
            last_mem_d = grant_mem_s;
        end else begin
            last_mem_d = last_mem_q;
        end
    end

    // Last-granted flag; resets to MEM so IF wins the first contest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem_q <= 1'b1;
        end else begin
            last_mem_q <= last_mem_d;
        end
    end
`else
    // Fixed priority grant: MEM always beats IF.
    always_comb begin
        grant_mem_s = mem_req_i;
        grant_if_s  = if_req_i && !mem_req_i;
    end
`endif

    // Next-state and RAM-side sequencing; cnt_q counts edges since the grant edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        ram_en_d    = ram_en_q;
        ram_wr_d    = ram_wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        nxt_s       = cnt_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (grant_mem_s) begin
                    state_d     = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                    len_d       = len_bytes(mem_len_i);
                    wdata_d     = mem_wdata_i;
                    asm_d       = 32'h0000_0000;
                    ram_en_d    = 1'b1;
                    ram_wr_d    = mem_we_i;
                    ram_addr_d  = mem_addr_i;
                    ram_wdata_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
                end else if (grant_if_s) begin
                    state_d     = ST_IF_RD;
                    len_d       = 3'd4;
                    asm_d       = 32'h0000_0000;
                    ram_en_d    = 1'b1;
                    ram_wr_d    = 1'b0;
                    ram_addr_d  = if_addr_i;
                    ram_wdata_d = 8'h00;
                end else begin
                    ram_en_d = 1'b0;
                    ram_wr_d = 1'b0;
                end
            end
            ST_IF_RD, ST_MEM_RD: begin
                cnt_d = nxt_s;
                if (nxt_s < len_q) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1'b1);
                end else begin
                    ram_en_d = 1'b0;
                end
                // RAM data lags its address by one cycle, so lane k lands two edges after it.
                if ((nxt_s >= 3'd2) && ((nxt_s - 3'd2) < len_q)) begin
                    asm_d = put_lane(asm_q, 2'(nxt_s - 3'd2), ram_data_i);
                end else begin
                    asm_d = asm_q;
                end
                if (nxt_s == (len_q + 3'd1)) begin
                    state_d    = ST_IDLE;
                    if_done_d  = (state_q == ST_IF_RD);
                    mem_done_d = (state_q == ST_MEM_RD);
                end else begin
                    state_d = state_q;
                end
            end
            ST_MEM_WR: begin
                cnt_d = nxt_s;
                if (nxt_s < len_q) begin
                    ram_en_d    = 1'b1;
                    ram_wr_d    = 1'b1;
                    ram_addr_d  = ram_addr_q + ADDR_W'(1'b1);
                    ram_wdata_d = get_lane(wdata_q, nxt_s[1:0]);
                end else begin
                    ram_en_d   = 1'b0;
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ram_en_d = 1'b0;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            wdata_q     <= 32'h0000_0000;
            asm_q       <= 32'h0000_0000;
            ram_en_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h00;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            ram_en_q    <= ram_en_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_data_o   = asm_q;
    assign mem_rdata_o = asm_q;
    assign if_done_o   = if_done_q;
    assign mem_done_o  = mem_done_q;
    assign ram_en_o    = ram_en_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule
